// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine: skews the A/B
// operand streams internally, accumulates in place, flushes, then drains C row by row.
module systolic_mm_engine #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K_W    = 8,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [K_W-1:0]           k_len_i,
    output logic                     busy_o,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ROWS*DATA_W-1:0]   a_i,
    input  logic [COLS*DATA_W-1:0]   b_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [COLS*ACC_W-1:0]    out_row_o,
    output logic [IDX_W-1:0]         out_row_idx_o,
    output logic                     out_last_o,
    output logic                     done_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int FL_W   = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0]  FLUSH_LOAD = FL_W'(ROWS + COLS - 2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROWS - 1);

    // state    | meaning
    // IDLE     | waiting for start; accumulators hold the previous result
    // FEED     | accepting k_len operand beats, bubbles inject zeros
    // FLUSH    | ROWS+COLS-1 zero-injection cycles to finish the wavefront
    // DRAIN    | presenting one C row per out_valid/out_ready handshake
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t           state_q;
    logic [K_W-1:0]   beat_cnt_q;
    logic [FL_W-1:0]  flush_cnt_q;
    logic [IDX_W-1:0] row_idx_q;
    logic             busy_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             done_q;

    logic arr_en;
    logic inject;
    logic clr_arr;

    assign arr_en  = (state_q == ST_FEED) || (state_q == ST_FLUSH);
    assign inject  = (state_q == ST_FEED) && in_valid_i;
    assign clr_arr = (state_q == ST_IDLE) && start_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_idx_q   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        beat_cnt_q <= k_len_i;
                        busy_q     <= 1'b1;
                        row_idx_q  <= '0;
                        if (k_len_i != '0) begin
                            state_q    <= ST_FEED;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DRAIN;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (ROWS == 1);
                        end
                    end
                end
                ST_FEED: begin
                    if (in_valid_i) begin
                        beat_cnt_q <= beat_cnt_q - 1'b1;
                        if (beat_cnt_q == K_W'(1)) begin
                            state_q     <= ST_FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= FLUSH_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q     <= ST_DRAIN;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (ROWS == 1);
                        row_idx_q   <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (row_idx_q == LAST_IDX) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            row_idx_q   <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            row_idx_q  <= row_idx_q + 1'b1;
                            out_last_q <= ((row_idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Operand values seen at each PE input; lane 0 of each packed vector in the LSBs.
    logic [ROWS-1:0][DATA_W-1:0]            a_inj;
    logic [COLS-1:0][DATA_W-1:0]            b_inj;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  a_pe;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  b_pe;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc_all;

    assign a_inj = inject ? a_i : '0;
    assign b_inj = inject ? b_i : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_none
            assign a_pe[0][0] = a_inj[0];
        end else begin : g_dly
            logic [DATA_W-1:0] sk_q [r];
            always_ff @(posedge clk_i) begin
                if (rst_i || clr_arr) begin
                    for (int i = 0; i < r; i++) sk_q[i] <= '0;
                end else if (arr_en) begin
                    sk_q[0] <= a_inj[r];
                    for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign a_pe[r][0] = sk_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_none
            assign b_pe[0][0] = b_inj[0];
        end else begin : g_dly
            logic [DATA_W-1:0] sk_q [c];
            always_ff @(posedge clk_i) begin
                if (rst_i || clr_arr) begin
                    for (int i = 0; i < c; i++) sk_q[i] <= '0;
                end else if (arr_en) begin
                    sk_q[0] <= b_inj[c];
                    for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign b_pe[0][c] = sk_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [PROD_W-1:0] a_ext;
            logic signed [PROD_W-1:0] b_ext;
            logic signed [PROD_W-1:0] prod;
            logic [ACC_W-1:0]         acc_q;

            assign a_ext = PROD_W'($signed(a_pe[r][c]));
            assign b_ext = PROD_W'($signed(b_pe[r][c]));
            assign prod  = a_ext * b_ext;

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_arr) begin
                    acc_q <= '0;
                end else if (arr_en) begin
                    acc_q <= acc_q + ACC_W'(prod);
                end
            end
            assign acc_all[r][c] = acc_q;

            // The last column/row has no neighbour, so its pass-through register is omitted.
            if (c < COLS - 1) begin : g_a_fwd
                logic [DATA_W-1:0] a_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i || clr_arr) a_q <= '0;
                    else if (arr_en)      a_q <= a_pe[r][c];
                end
                assign a_pe[r][c+1] = a_q;
            end

            if (r < ROWS - 1) begin : g_b_fwd
                logic [DATA_W-1:0] b_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i || clr_arr) b_q <= '0;
                    else if (arr_en)      b_q <= b_pe[r][c];
                end
                assign b_pe[r+1][c] = b_q;
            end
        end
    end

    assign busy_o        = busy_q;
    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_last_o    = out_last_q;
    assign done_o        = done_q;
    assign out_row_idx_o = row_idx_q;
    assign out_row_o     = out_valid_q ? acc_all[row_idx_q] : '0;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine: a reference matrix product is queued per
// job and a negedge monitor compares every drained row, hold behaviour and done timing.
module tb_systolic_mm_engine;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int K_W    = 8;
    localparam int MAXK   = 16;
    localparam int RW     = COLS * ACC_W;

    typedef struct {
        logic [RW-1:0] row;
        int            idx;
        bit            last;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   start_i;
    logic [K_W-1:0]         k_len_i;
    logic                   busy_o;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [ROWS*DATA_W-1:0] a_i;
    logic [COLS*DATA_W-1:0] b_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [RW-1:0]          out_row_o;
    logic [1:0]             out_row_idx_o;
    logic                   out_last_o;
    logic                   done_o;

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
        .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_row_o(out_row_o), .out_row_idx_o(out_row_idx_o),
        .out_last_o(out_last_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    int   am [ROWS][MAXK];
    int   bm [MAXK][COLS];

    bit            mon_en       = 0;
    bit            done_pending = 0;
    bit            done_seen    = 0;
    bit            first_seen   = 0;
    bit            hold_valid   = 0;
    logic [RW-1:0] hold_row;
    logic [1:0]    hold_idx;
    int            first_valid_n;
    int            start_cyc;
    int            feed_cnt;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                hold_valid   = 0;
                done_pending = 0;
            end else if (mon_en) begin
                if (in_ready_o) feed_cnt++;
                if (done_pending) begin
                    chk("done_pulse", RW'(done_o), RW'(1));
                    done_pending = 0;
                    done_seen    = 1;
                end else if (done_o) begin
                    chk("spurious_done", RW'(done_o), RW'(0));
                end
                if (out_valid_o) begin
                    if (!first_seen) begin
                        first_seen    = 1;
                        first_valid_n = cyc - start_cyc;
                    end
                    if (hold_valid) begin
                        chk("hold_row", out_row_o, hold_row);
                        chk("hold_idx", RW'(out_row_idx_o), RW'(hold_idx));
                    end
                    if (out_ready_i) begin
                        hold_valid = 0;
                        if (exp_q.size() == 0) begin
                            chk("extra_row", RW'(out_valid_o), RW'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("row_data", out_row_o, e.row);
                            chk("row_idx", RW'(out_row_idx_o), RW'(e.idx));
                            chk("row_last", RW'(out_last_o), RW'(e.last));
                            if (e.last) done_pending = 1;
                        end
                    end else begin
                        hold_valid = 1;
                        hold_row   = out_row_o;
                        hold_idx   = out_row_idx_o;
                    end
                end else begin
                    hold_valid = 0;
                end
            end
        end
    end

    task automatic push_expected(input int k);
        exp_t          e;
        longint        s;
        logic [RW-1:0] row;
        for (int r = 0; r < ROWS; r++) begin
            row = '0;
            for (int c = 0; c < COLS; c++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(am[r][kk]) * longint'(bm[kk][c]);
                row[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
            e.row  = row;
            e.idx  = r;
            e.last = (r == ROWS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input int beat);
        for (int r = 0; r < ROWS; r++) a_i[r*DATA_W +: DATA_W] = DATA_W'(am[r][beat]);
        for (int c = 0; c < COLS; c++) b_i[c*DATA_W +: DATA_W] = DATA_W'(bm[beat][c]);
    endtask

    task automatic set_identity();
        for (int kk = 0; kk < MAXK; kk++) begin
            for (int r = 0; r < ROWS; r++) am[r][kk] = (r == kk) ? 1 : 0;
            for (int c = 0; c < COLS; c++) bm[kk][c] = 4 * kk + c + 1;
        end
    endtask

    task automatic set_const(input int av, input int bv);
        for (int kk = 0; kk < MAXK; kk++) begin
            for (int r = 0; r < ROWS; r++) am[r][kk] = av;
            for (int c = 0; c < COLS; c++) bm[kk][c] = bv;
        end
    endtask

    task automatic set_random();
        for (int kk = 0; kk < MAXK; kk++) begin
            for (int r = 0; r < ROWS; r++) am[r][kk] = int'($urandom_range(0, 65535)) - 32768;
            for (int c = 0; c < COLS; c++) bm[kk][c] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // vmode: 0 valid held high, 1 toggling (valid in the start cycle, then 0,1,0,1...), 2 random
    // rmode: 0 ready held high, 1 ready low 5 cycles at row 1, 2 random
    task automatic run_job(input int k, input int vmode, input int rmode, input bit start_in_drain);
        int n, beats, exp_feed, held, exp_first;
        bit v;
        push_expected(k);
        @(posedge clk_i); #1;
        start_cyc   = cyc;
        first_seen  = 0;
        done_seen   = 0;
        feed_cnt    = 0;
        start_i     = 1'b1;
        k_len_i     = K_W'(k);
        in_valid_i  = 1'b1;
        a_i         = {$urandom(), $urandom()};
        b_i         = {$urandom(), $urandom()};
        out_ready_i = 1'b1;
        n = 0;
        beats = 0;
        while (beats < k) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            n++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid_i = v;
            if (v) begin
                drive_beat(beats);
                beats++;
            end else begin
                a_i = {$urandom(), $urandom()};
                b_i = {$urandom(), $urandom()};
            end
        end
        exp_feed = n;
        held = 0;
        n = 0;
        while (!done_seen && n < 400) begin
            @(posedge clk_i); #1;
            n++;
            start_i    = start_in_drain && (n <= 3);
            in_valid_i = 1'($urandom_range(0, 1));
            a_i        = {$urandom(), $urandom()};
            b_i        = {$urandom(), $urandom()};
            case (rmode)
                0: out_ready_i = 1'b1;
                1: begin
                    if (out_valid_o && out_row_idx_o == 2'd1 && held < 5) begin
                        out_ready_i = 1'b0;
                        held++;
                    end else begin
                        out_ready_i = 1'b1;
                    end
                end
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (start_in_drain && n == 3) begin
                chk("drain_start_ignored_ready", RW'(in_ready_o), RW'(0));
                chk("drain_start_ignored_busy", RW'(busy_o), RW'(1));
            end
        end
        start_i = 1'b0;
        if (!done_seen) chk("job_timeout", RW'(done_seen), RW'(1));
        exp_first = (k == 0) ? 1 : exp_feed + ROWS + COLS;
        chk("first_valid_cycle", RW'(first_valid_n), RW'(exp_first));
        chk("feed_length", RW'(feed_cnt), RW'((k == 0) ? 0 : exp_feed));
        chk("rows_left", RW'(exp_q.size()), RW'(0));
        exp_q.delete();
    endtask

    task automatic abort_job();
        set_identity();
        @(posedge clk_i); #1;
        start_i    = 1'b1;
        k_len_i    = K_W'(4);
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        drive_beat(0);
        @(posedge clk_i); #1;
        drive_beat(1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        drive_beat(2);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", RW'(busy_o), RW'(0));
        chk("abort_in_ready", RW'(in_ready_o), RW'(0));
        chk("abort_out_valid", RW'(out_valid_o), RW'(0));
        repeat (4) @(posedge clk_i);
        #1 in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        k_len_i     = '0;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_busy", RW'(busy_o), RW'(0));
        chk("reset_in_ready", RW'(in_ready_o), RW'(0));
        chk("reset_out_valid", RW'(out_valid_o), RW'(0));
        chk("reset_out_last", RW'(out_last_o), RW'(0));
        chk("reset_done", RW'(done_o), RW'(0));
        chk("reset_out_row", out_row_o, RW'(0));
        chk("reset_out_row_idx", RW'(out_row_idx_o), RW'(0));
        mon_en = 1;

        set_identity();
        run_job(4, 0, 0, 0);
        run_job(4, 1, 0, 0);
        run_job(4, 0, 1, 0);

        set_const(-32768, -32768);
        run_job(2, 0, 0, 0);
        set_const(-1, 3);
        run_job(5, 0, 0, 0);
        set_const(-1, -3);
        run_job(5, 0, 1, 0);

        run_job(0, 0, 0, 1);

        abort_job();
        set_identity();
        run_job(4, 0, 0, 0);

        for (int j = 0; j < 8; j++) begin
            set_random();
            run_job(int'($urandom_range(0, 12)), 2, 2, 0);
        end

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
